// File: rtl/nn_layer_mac_engine.sv
// nn_layer_mac_engine
// Fully-connected layer engine. Streams one frame of N_IN unsigned pixels and
// reads the matching weight row from an external synchronous ROM (1-cycle
// latency). It accumulates N_OUT dot products in parallel, with saturation.
//
// Ports
//   pclk          clock, rising edge
//   rst           synchronous reset, active low
//   frame_start   pulse: clear lanes and begin a new frame (any state)
//   pixel_valid   pixel_in valid this cycle
//   pixel_in      unsigned pixel, PIX_W bits
//   rom_addr      weight ROM address (current pixel index)
//   weights_row   ROM q; lane k = [k*W_W +: W_W]
//   acc_out       lane results; lane k = [k*ACC_W +: ACC_W]
//   sat_flags     sticky per-lane saturation indicator
//   result_valid  one-cycle pulse when acc_out holds the final frame result
//   busy          high in ACCUM and DRAIN
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for frame_start; acc_out holds last result
// ACCUM | accepting pixels until index N_IN-1 has been taken
// DRAIN | last pipe entry lands in the lanes
// DONE  | result_valid high for this single cycle
module nn_layer_mac_engine #(
  parameter int N_OUT    = 10,
  parameter int N_IN     = 784,
  parameter int PIX_W    = 8,
  parameter int W_W      = 8,
  parameter int ACC_W    = 32,
  parameter int ADDR_W   = 10,
  parameter bit SIGNED_W = 1'b1
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   pixel_valid,
  input  logic [PIX_W-1:0]       pixel_in,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [N_OUT*W_W-1:0]   weights_row,
  output logic [N_OUT*ACC_W-1:0] acc_out,
  output logic [N_OUT-1:0]       sat_flags,
  output logic                   result_valid,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0]       LAST_IDX = ADDR_W'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                    state, state_nxt;
  logic [ADDR_W-1:0]         idx;
  logic [PIX_W-1:0]          pix_q;
  logic                      pipe_vld;
  logic                      accept;
  logic signed [ACC_W-1:0]   acc     [N_OUT];
  logic signed [ACC_W-1:0]   acc_nxt [N_OUT];
  logic [N_OUT-1:0]          sat_hit;
  logic [N_OUT-1:0]          sat_q;

  assign accept = (state == ACCUM) && pixel_valid && !frame_start;

  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        ACCUM:   if (accept && (idx == LAST_IDX)) state_nxt = DRAIN;
        DRAIN:   state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Lane arithmetic is done at ACC_W+1 bits. Because the running sum is
  // always held in range, the top two bits of the wide sum show overflow
  // (01) or underflow (10) directly.
  always_comb begin
    logic signed [ACC_W:0] w_ext;
    logic signed [ACC_W:0] p_ext;
    logic signed [ACC_W:0] prod;
    logic signed [ACC_W:0] sum;
    w_ext   = '0;
    p_ext   = '0;
    prod    = '0;
    sum     = '0;
    sat_hit = '0;
    for (int k = 0; k < N_OUT; k++) begin
      acc_nxt[k] = acc[k];
      if (SIGNED_W) begin
        w_ext = {{(ACC_W+1-W_W){weights_row[k*W_W+W_W-1]}}, weights_row[k*W_W +: W_W]};
      end else begin
        w_ext = {{(ACC_W+1-W_W){1'b0}}, weights_row[k*W_W +: W_W]};
      end
      p_ext = {{(ACC_W+1-PIX_W){1'b0}}, pix_q};
      prod  = p_ext * w_ext;
      sum   = {acc[k][ACC_W-1], acc[k]} + prod;
      if (sum[ACC_W:ACC_W-1] == 2'b01) begin
        acc_nxt[k] = ACC_MAX;
        sat_hit[k] = 1'b1;
      end else if (sum[ACC_W:ACC_W-1] == 2'b10) begin
        acc_nxt[k] = ACC_MIN;
        sat_hit[k] = 1'b1;
      end else begin
        acc_nxt[k] = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      pix_q    <= '0;
      pipe_vld <= 1'b0;
      sat_q    <= '0;
      for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
    end else begin
      state <= state_nxt;
      if (frame_start) begin
        // A pending pipe entry belongs to the abandoned frame: drop it.
        idx      <= '0;
        pipe_vld <= 1'b0;
        sat_q    <= '0;
        for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
      end else begin
        pipe_vld <= accept;
        if (accept) begin
          pix_q <= pixel_in;
          idx   <= idx + 1'b1;
        end
        if (pipe_vld) begin
          for (int k = 0; k < N_OUT; k++) acc[k] <= acc_nxt[k];
          sat_q <= sat_q | sat_hit;
        end
      end
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_lane_out
    assign acc_out[g*ACC_W +: ACC_W] = acc[g];
  end

  assign rom_addr     = idx;
  assign sat_flags    = sat_q;
  assign result_valid = (state == DONE);
  assign busy         = (state == ACCUM) || (state == DRAIN);

endmodule

// File: tb/tb_nn_layer_mac_engine.sv
// Bench for nn_layer_mac_engine: three instances (32-bit signed, 16-bit
// signed, 32-bit unsigned weights) share stimulus; each has its own ROM model.
module tb_nn_layer_mac_engine;
  localparam int N_OUT = 3;
  localparam int N_IN  = 4;

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [7:0]  pixel_in = '0;
  logic [9:0]  addr_a, addr_b, addr_c;
  logic [23:0] row_a = '0, row_b = '0, row_c = '0;
  logic [95:0] acc_a, acc_c;
  logic [47:0] acc_b;
  logic [2:0]  sat_a, sat_b, sat_c;
  logic        rv_a, rv_b, rv_c, busy_a, busy_b, busy_c;

  logic [7:0]  w_mem [4][3];
  longint      exp_a [3];
  longint      exp_b [3];
  longint      exp_c [3];
  logic [2:0]  exp_sa, exp_sb, exp_sc;
  int          total = 0;
  int          bad = 0;

  always #5 pclk = ~pclk;

  nn_layer_mac_engine #(.N_OUT(3), .N_IN(4), .ACC_W(32), .SIGNED_W(1'b1)) dut_a (
    .pclk(pclk), .rst(rst), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .pixel_in(pixel_in), .rom_addr(addr_a), .weights_row(row_a), .acc_out(acc_a),
    .sat_flags(sat_a), .result_valid(rv_a), .busy(busy_a));

  nn_layer_mac_engine #(.N_OUT(3), .N_IN(4), .ACC_W(16), .SIGNED_W(1'b1)) dut_b (
    .pclk(pclk), .rst(rst), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .pixel_in(pixel_in), .rom_addr(addr_b), .weights_row(row_b), .acc_out(acc_b),
    .sat_flags(sat_b), .result_valid(rv_b), .busy(busy_b));

  nn_layer_mac_engine #(.N_OUT(3), .N_IN(4), .ACC_W(32), .SIGNED_W(1'b0)) dut_c (
    .pclk(pclk), .rst(rst), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .pixel_in(pixel_in), .rom_addr(addr_c), .weights_row(row_c), .acc_out(acc_c),
    .sat_flags(sat_c), .result_valid(rv_c), .busy(busy_c));

  function automatic logic [23:0] rom_row(input logic [9:0] a);
    logic [23:0] r;
    r = '0;
    if (a < 10'd4) for (int k = 0; k < 3; k++) r[k*8 +: 8] = w_mem[a[1:0]][k];
    return r;
  endfunction

  always @(posedge pclk) begin
    row_a <= rom_row(addr_a);
    row_b <= rom_row(addr_b);
    row_c <= rom_row(addr_c);
  end

  function automatic longint lane_a(input int k);
    logic signed [31:0] t;
    t = acc_a[k*32 +: 32];
    return t;
  endfunction
  function automatic longint lane_b(input int k);
    logic signed [15:0] t;
    t = acc_b[k*16 +: 16];
    return t;
  endfunction
  function automatic longint lane_c(input int k);
    logic signed [31:0] t;
    t = acc_c[k*32 +: 32];
    return t;
  endfunction

  // Reference: sequential saturating sum over the frame, plain integer math.
  function automatic longint model_lane(input int lane, input logic [3:0][7:0] pix,
                                        input int acc_w, input bit sgn, output bit sat);
    longint acc, mx, mn, w;
    acc = 0;
    sat = 1'b0;
    mx = (longint'(1) << (acc_w - 1)) - 1;
    mn = -mx - 1;
    for (int i = 0; i < N_IN; i++) begin
      w = longint'(w_mem[i][lane]);
      if (sgn && w > 127) w = w - 256;
      acc = acc + longint'(pix[i]) * w;
      if (acc > mx) begin
        acc = mx;
        sat = 1'b1;
      end else if (acc < mn) begin
        acc = mn;
        sat = 1'b1;
      end
    end
    return acc;
  endfunction

  task automatic set_model_exp(input logic [3:0][7:0] pix);
    bit s;
    for (int k = 0; k < 3; k++) begin
      exp_a[k] = model_lane(k, pix, 32, 1'b1, s); exp_sa[k] = s;
      exp_b[k] = model_lane(k, pix, 16, 1'b1, s); exp_sb[k] = s;
      exp_c[k] = model_lane(k, pix, 32, 1'b0, s); exp_sc[k] = s;
    end
  endtask

  task automatic check(input string nm, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic check_results(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_a_lane%0d", tag, k), lane_a(k), exp_a[k]);
      check($sformatf("%s_b_lane%0d", tag, k), lane_b(k), exp_b[k]);
      check($sformatf("%s_c_lane%0d", tag, k), lane_c(k), exp_c[k]);
    end
    check({tag, "_sat_a"}, longint'(sat_a), longint'(exp_sa));
    check({tag, "_sat_b"}, longint'(sat_b), longint'(exp_sb));
    check({tag, "_sat_c"}, longint'(sat_c), longint'(exp_sc));
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(negedge pclk);
    frame_start = 1'b0;
  endtask

  task automatic push_pixels(input int n, input logic [7:0] val);
    for (int i = 0; i < n; i++) begin
      pixel_valid = 1'b1;
      pixel_in = val;
      @(negedge pclk);
    end
    pixel_valid = 1'b0;
  endtask

  // Starts a frame and feeds it; returns at the negedge inside DONE.
  task automatic run_frame(input logic [3:0][7:0] pix, input int max_gap, input bit noisy);
    int g;
    frame_start = 1'b1;
    pixel_valid = noisy;
    pixel_in = 8'hAA;
    @(negedge pclk);
    frame_start = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      g = $urandom_range(max_gap, 0);
      repeat (g) begin
        pixel_valid = 1'b0;
        @(negedge pclk);
      end
      check($sformatf("rom_addr_%0d", i), longint'(addr_a), longint'(i));
      pixel_valid = 1'b1;
      pixel_in = pix[i];
      @(negedge pclk);
    end
    pixel_valid = noisy ? 1'($urandom) : 1'b0;
    pixel_in = 8'($urandom);
    check("drain_rv_busy", longint'({rv_a, rv_b, rv_c, busy_a, busy_b, busy_c}), 64'd7);
    @(negedge pclk);
    pixel_valid = noisy ? 1'($urandom) : 1'b0;
    pixel_in = 8'($urandom);
    check("done_rv_busy", longint'({rv_a, rv_b, rv_c, busy_a, busy_b, busy_c}), 64'd56);
  endtask

  // Checks results at DONE, then confirms pulse end, hold, and IDLE pixel drop.
  task automatic finish_frame(input string tag);
    check_results(tag);
    @(negedge pclk);
    check({tag, "_idle_rv_busy"}, longint'({rv_a, busy_a, rv_b, busy_b}), 64'd0);
    pixel_valid = 1'b1;
    pixel_in = 8'd99;
    @(negedge pclk);
    @(negedge pclk);
    pixel_valid = 1'b0;
    check({tag, "_idle_addr"}, longint'(addr_a), longint'(N_IN));
    check_results({tag, "_hold"});
  endtask

  typedef struct {
    logic [3:0][2:0][7:0] w;
    logic [3:0][7:0]      pix;
    logic [2:0][31:0]     ea, eb, ec;
    logic [2:0]           sa, sb, sc;
  } vec_t;

  vec_t vecs[4];

  task automatic load_vec(input vec_t v);
    logic signed [31:0] t;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) w_mem[i][k] = v.w[i][k];
    for (int k = 0; k < 3; k++) begin
      t = v.ea[k]; exp_a[k] = t;
      t = v.eb[k]; exp_b[k] = t;
      t = v.ec[k]; exp_c[k] = t;
    end
    exp_sa = v.sa;
    exp_sb = v.sb;
    exp_sc = v.sc;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0][7:0] rpix;
    logic [3:0][7:0] ones;
    ones = {4{8'd1}};

    vecs[0].w   = {4{8'd1, 8'd1, 8'd1}};
    vecs[0].pix = {8'd40, 8'd30, 8'd20, 8'd10};
    vecs[0].ea  = {3{32'd100}};
    vecs[0].eb  = {3{32'd100}};
    vecs[0].ec  = {3{32'd100}};
    vecs[0].sa  = 3'b000; vecs[0].sb = 3'b000; vecs[0].sc = 3'b000;

    vecs[1].w   = {4{8'h7F, 8'h80, 8'hFF}};
    vecs[1].pix = {4{8'd255}};
    vecs[1].ea  = {32'd129540, -32'sd130560, -32'sd1020};
    vecs[1].eb  = {32'd32767, -32'sd32768, -32'sd1020};
    vecs[1].ec  = {32'd129540, 32'd130560, 32'd260100};
    vecs[1].sa  = 3'b000; vecs[1].sb = 3'b110; vecs[1].sc = 3'b000;

    vecs[2].w   = {4{8'h7F, 8'h7F, 8'h7F}};
    vecs[2].pix = {4{8'd255}};
    vecs[2].ea  = {3{32'd129540}};
    vecs[2].eb  = {3{32'd32767}};
    vecs[2].ec  = {3{32'd129540}};
    vecs[2].sa  = 3'b000; vecs[2].sb = 3'b111; vecs[2].sc = 3'b000;

    // lane0 saturates high, then walks back into range
    vecs[3].w   = {8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h80,
                   8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h7F};
    vecs[3].pix = {4{8'd255}};
    vecs[3].ea  = {32'd0, 32'd0, -32'sd510};
    vecs[3].eb  = {32'd0, 32'd0, -32'sd32513};
    vecs[3].ec  = {32'd0, 32'd0, 32'd130050};
    vecs[3].sa  = 3'b000; vecs[3].sb = 3'b001; vecs[3].sc = 3'b000;

    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) w_mem[i][k] = 8'd0;

    // reset dominates frame_start and pixel_valid
    rst = 1'b0;
    frame_start = 1'b1;
    pixel_valid = 1'b1;
    pixel_in = 8'd5;
    repeat (3) @(negedge pclk);
    check("reset_outputs", longint'({rv_a, busy_a, sat_a, addr_a, rv_b, busy_b, sat_b}), 64'd0);
    check("reset_acc", longint'(acc_a != '0 || acc_b != '0 || acc_c != '0), 64'd0);
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    rst = 1'b1;
    @(negedge pclk);
    check("post_reset_idle", longint'({busy_a, rv_a, addr_a}), 64'd0);

    // table vectors; the last pass repeats vector 0 with random gaps
    for (int r = 0; r < 5; r++) begin
      load_vec(vecs[r % 4]);
      run_frame(vecs[r % 4].pix, (r == 4) ? 3 : 0, 1'b0);
      finish_frame($sformatf("vec%0d", r));
      if (r == 2) begin
        pulse_start();
        check("restart_clears_acc_b", longint'(acc_b), 64'd0);
        check("restart_clears_sat_b", longint'(sat_b), 64'd0);
      end
    end

    // abort after 2 pixels; restart cycle carries a pixel that must be dropped
    load_vec(vecs[0]);
    for (int k = 0; k < 3; k++) begin
      exp_a[k] = 4; exp_b[k] = 4; exp_c[k] = 4;
    end
    pulse_start();
    push_pixels(2, 8'd50);
    check("abort_no_rv", longint'(rv_a), 64'd0);
    run_frame(ones, 0, 1'b1);
    finish_frame("abort");

    // frame_start in DRAIN discards the in-flight pixel and the pending result
    pulse_start();
    push_pixels(4, 8'd200);
    check("drain_state", longint'({busy_a, rv_a}), 64'd2);
    frame_start = 1'b1;
    @(negedge pclk);
    frame_start = 1'b0;
    check("drain_restart_acc", longint'(lane_a(0)), 64'd0);
    check("drain_restart_ctrl", longint'({busy_a, rv_a, addr_a}), 64'h800);
    @(negedge pclk);
    check("drain_restart_no_rv", longint'({rv_a, lane_a(1) != 0}), 64'd0);
    run_frame(ones, 0, 1'b0);
    finish_frame("drain_abort");

    // reset mid-ACCUM, then stray pixels must be ignored until frame_start
    pulse_start();
    push_pixels(2, 8'd9);
    rst = 1'b0;
    @(negedge pclk);
    rst = 1'b1;
    check("midreset_outputs", longint'({rv_a, busy_a, sat_a, addr_a}), 64'd0);
    check("midreset_acc", longint'(acc_a != '0), 64'd0);
    push_pixels(3, 8'd5);
    @(negedge pclk);
    check("midreset_ignored", longint'({busy_a, addr_a, acc_a != '0}), 64'd0);
    run_frame(ones, 0, 1'b1);
    finish_frame("midreset");

    // random frames against the reference model
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 4; i++) begin
        rpix[i] = (r % 3 == 0) ? 8'(8'd200 + 8'($urandom_range(55, 0))) : 8'($urandom);
        for (int k = 0; k < 3; k++) w_mem[i][k] = 8'($urandom);
      end
      set_model_exp(rpix);
      run_frame(rpix, 3, 1'b1);
      finish_frame($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
